xentry_dcache: RTL and testbench

//   Direct-mapped, write-back, write-allocate L1 data cache between the pipeline load/store unit and L2.

---
 rtl/xentry_dcache.sv | 206 ++++++++++++++++++++
 tb/tb_xentry_dcache.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/xentry_dcache.sv
// xentry_dcache -- direct-mapped, write-back, write-allocate L1 data cache.
//
// Sits between the pipeline load/store unit and L2. Hits complete combinationally
// in the request cycle. A miss first writes a dirty victim back word-by-word
// (WRITEBACK), then refills the line from L2 (FILL), and then returns to IDLE,
// where the still-held request hits.
//
// Ports
//   clk_i, reset_i            clock; asynchronous active-low reset
//   pipe_req_*_i              request address/size/type/valid, store data (right-aligned)
//   pipe_fetched_word_o       zero-extended load data (valid with pipe_req_fulfilled_o)
//   pipe_req_fulfilled_o      request completes this cycle (IDLE hit only)
//   l2_req_*_o                word-aligned L2 request: LOAD = refill, STORE = write-back
//   l2_fetched_word_i         refill data
//   l2_req_fulfilled_i        L2 completes the current word
//
// Build option: define DCACHE_DEBUG_PRINT_EN for simulation-only trace prints
// (hits, misses, write-back words, fill words). Function and timing are the same
// with or without it.

package xentry_pkg;
   typedef enum logic {LOAD = 1'b0, STORE = 1'b1} memory_operation_e;
   typedef enum logic [1:0] {BYTE = 2'd0, HALF = 2'd1, WORD = 2'd2} memory_operation_size_e;
endpackage

module xentry_dcache
   import xentry_pkg::*;
#(
   parameter int LINE_SIZE  = 16,
   parameter int CACHE_SIZE = 256,
   parameter int XLEN       = 32
) (
   input  logic                   clk_i,
   input  logic                   reset_i,
   input  logic [XLEN-1:0]        pipe_req_address_i,
   input  memory_operation_size_e pipe_req_size_i,
   input  memory_operation_e      pipe_req_type_i,
   input  logic                   pipe_req_valid_i,
   input  logic [XLEN-1:0]        pipe_word_to_store_i,
   output logic [XLEN-1:0]        pipe_fetched_word_o,
   output logic                   pipe_req_fulfilled_o,
   output logic [XLEN-1:0]        l2_req_address_o,
   output memory_operation_e      l2_req_type_o,
   output logic                   l2_req_valid_o,
   output logic [XLEN-1:0]        l2_word_to_store_o,
   input  logic [XLEN-1:0]        l2_fetched_word_i,
   input  logic                   l2_req_fulfilled_i
);

   localparam int NUM_LINES = CACHE_SIZE / LINE_SIZE;
   localparam int BYTES     = XLEN / 8;
   localparam int WPL       = LINE_SIZE / BYTES;
   localparam int OFF_W     = $clog2(BYTES);
   localparam int WSEL_W    = $clog2(WPL);
   localparam int IDX_W     = $clog2(NUM_LINES);
   localparam int TAG_W     = XLEN - IDX_W - WSEL_W - OFF_W;

   typedef enum logic [1:0] {S_IDLE, S_WB, S_FILL} state_e;

   state_e                        state_q;
   logic [WSEL_W-1:0]             cnt_q;
   logic [NUM_LINES-1:0]          valid_q, dirty_q;
   logic [TAG_W-1:0]              tag_q  [NUM_LINES];
   logic [XLEN-1:0]               data_q [NUM_LINES][WPL];

   // Address split
   logic [OFF_W-1:0]  boff;
   logic [WSEL_W-1:0] wsel;
   logic [IDX_W-1:0]  idx;
   logic [TAG_W-1:0]  tag;
   assign boff = pipe_req_address_i[OFF_W-1:0];
   assign wsel = pipe_req_address_i[OFF_W +: WSEL_W];
   assign idx  = pipe_req_address_i[OFF_W+WSEL_W +: IDX_W];
   assign tag  = pipe_req_address_i[XLEN-1 -: TAG_W];

   logic             hit, miss, st_hit, l2_done, last;
   logic [OFF_W-1:0] aoff;
   logic [OFF_W+2:0] shamt;
   logic [BYTES-1:0] be;
   logic [XLEN-1:0]  szmask, rd_word, st_shift, merged;

   assign hit     = (state_q == S_IDLE) & pipe_req_valid_i & valid_q[idx] & (tag_q[idx] == tag);
   assign miss    = (state_q == S_IDLE) & pipe_req_valid_i & ~hit;
   assign st_hit  = hit & (pipe_req_type_i == STORE);
   assign l2_done = l2_req_valid_o & l2_req_fulfilled_i;
   assign last    = (cnt_q == WSEL_W'(WPL - 1));

   // Size decode: misaligned HALF/WORD addresses are silently aligned down.
   always_comb begin
      aoff   = boff;
      szmask = '0;
      be     = '0;
      case (pipe_req_size_i)
         BYTE: begin
            aoff   = boff;
            szmask = XLEN'(8'hFF);
         end
         HALF: begin
            aoff   = boff & ~OFF_W'(1);
            szmask = XLEN'(16'hFFFF);
         end
         default: begin
            aoff   = boff & ~OFF_W'(3);
            szmask = XLEN'(32'hFFFF_FFFF);
         end
      endcase
      shamt    = {aoff, 3'b000};
      rd_word  = data_q[idx][wsel];
      st_shift = pipe_word_to_store_i << shamt;
      for (int b = 0; b < BYTES; b++)
         be[b] = szmask[8*b] ? 1'b1 : 1'b0;
      be = be << aoff;
      merged = rd_word;
      for (int b = 0; b < BYTES; b++)
         if (be[b]) merged[8*b +: 8] = st_shift[8*b +: 8];
   end

   assign pipe_req_fulfilled_o = hit;
   assign pipe_fetched_word_o  = hit ? ((rd_word >> shamt) & szmask) : '0;

   // L2 request decode; all fields idle at zero/LOAD outside a miss.
   always_comb begin
      l2_req_valid_o     = 1'b0;
      l2_req_type_o      = LOAD;
      l2_req_address_o   = '0;
      l2_word_to_store_o = '0;
      case (state_q)
         S_WB: begin
            l2_req_valid_o     = 1'b1;
            l2_req_type_o      = STORE;
            l2_req_address_o   = {tag_q[idx], idx, cnt_q, OFF_W'(0)};
            l2_word_to_store_o = data_q[idx][cnt_q];
         end
         S_FILL: begin
            l2_req_valid_o   = 1'b1;
            l2_req_address_o = {tag, idx, cnt_q, OFF_W'(0)};
         end
         default: ;
      endcase
   end

   // Control FSM and line status bits
   always_ff @(posedge clk_i or negedge reset_i) begin
      if (!reset_i) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         valid_q <= '0;
         dirty_q <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (st_hit) begin
                  dirty_q[idx] <= 1'b1;
               end else if (miss) begin
                  cnt_q   <= '0;
                  state_q <= (valid_q[idx] & dirty_q[idx]) ? S_WB : S_FILL;
               end
            end
            S_WB: if (l2_done) begin
               // counter wraps to 0 after the last word, ready for FILL
               cnt_q <= cnt_q + WSEL_W'(1);
               if (last) begin
                  dirty_q[idx] <= 1'b0;
                  state_q      <= S_FILL;
               end
            end
            S_FILL: if (l2_done) begin
               cnt_q <= cnt_q + WSEL_W'(1);
               if (last) begin
                  valid_q[idx] <= 1'b1;
                  dirty_q[idx] <= 1'b0;
                  state_q      <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   // Data and tag arrays (no reset; guarded by valid bits)
   always_ff @(posedge clk_i) begin
      if (st_hit)
         data_q[idx][wsel] <= merged;
      if ((state_q == S_FILL) && l2_done) begin
         data_q[idx][cnt_q] <= l2_fetched_word_i;
         if (last) tag_q[idx] <= tag;
      end
   end

`ifdef DCACHE_DEBUG_PRINT_EN
   always_ff @(posedge clk_i) begin
      if (hit)
         $display("dcache hit   addr=%h data=%h idx=%0d", pipe_req_address_i,
                  (pipe_req_type_i == STORE) ? merged : pipe_fetched_word_o, idx);
      if (miss)
         $display("dcache miss  addr=%h idx=%0d", pipe_req_address_i, idx);
      if ((state_q == S_WB) && l2_done)
         $display("dcache wb    addr=%h data=%h idx=%0d", l2_req_address_o, l2_word_to_store_o, idx);
      if ((state_q == S_FILL) && l2_done)
         $display("dcache fill  addr=%h data=%h idx=%0d", l2_req_address_o, l2_fetched_word_i, idx);
   end
`else
   // trace prints disabled
`endif

endmodule

// File: tb/tb_xentry_dcache.sv
// Scoreboard bench for xentry_dcache: stimulus pushes expected pipe responses and
// expected L2 transactions into queues; two monitors pop and compare on negedge.
module tb_xentry_dcache;
   import xentry_pkg::*;

   logic                   clk = 1'b0;
   logic                   reset_n;
   logic [31:0]            pipe_req_address;
   memory_operation_size_e pipe_req_size;
   memory_operation_e      pipe_req_type;
   logic                   pipe_req_valid;
   logic [31:0]            pipe_word_to_store;
   logic [31:0]            pipe_fetched_word;
   logic                   pipe_req_fulfilled;
   logic [31:0]            l2_req_address;
   memory_operation_e      l2_req_type;
   logic                   l2_req_valid;
   logic [31:0]            l2_word_to_store;
   logic [31:0]            l2_fetched_word;
   logic                   l2_req_fulfilled;

   xentry_dcache dut (
      .clk_i(clk), .reset_i(reset_n),
      .pipe_req_address_i(pipe_req_address), .pipe_req_size_i(pipe_req_size),
      .pipe_req_type_i(pipe_req_type), .pipe_req_valid_i(pipe_req_valid),
      .pipe_word_to_store_i(pipe_word_to_store), .pipe_fetched_word_o(pipe_fetched_word),
      .pipe_req_fulfilled_o(pipe_req_fulfilled), .l2_req_address_o(l2_req_address),
      .l2_req_type_o(l2_req_type), .l2_req_valid_o(l2_req_valid),
      .l2_word_to_store_o(l2_word_to_store), .l2_fetched_word_i(l2_fetched_word),
      .l2_req_fulfilled_i(l2_req_fulfilled)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct { logic ld; logic [31:0] d; int issue; int lat; } pexp_t;
   typedef struct { logic st; logic [31:0] a; logic [31:0] d; } lexp_t;
   pexp_t pq[$];
   lexp_t lq[$];

   // L2 memory: sparse overrides on top of an address hash
   logic [31:0] mem [logic [31:0]];
   int mem_gen = 0;

   function automatic logic [31:0] dflt(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] rd(input logic [31:0] a);
      if (mem.exists(a)) return mem[a];
      return dflt(a);
   endfunction

   function automatic logic [31:0] ext(input logic [31:0] w, input logic [31:0] a,
                                       input memory_operation_size_e sz);
      case (sz)
         BYTE:    return (w >> (8 * a[1:0])) & 32'hFF;
         HALF:    return (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
         default: return w;
      endcase
   endfunction

   // zero-wait L2
   assign l2_req_fulfilled = l2_req_valid;
   always @(l2_req_address or mem_gen) l2_fetched_word = rd(l2_req_address);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   // pipe response monitor
   always @(negedge clk) begin
      pexp_t e;
      if (pipe_req_valid && pipe_req_fulfilled) begin
         if (pq.size() == 0) begin
            checks++; failures++;
            $display("FAIL pipe_unexpected actual=fulfilled required=none addr=%h", pipe_req_address);
         end else begin
            e = pq.pop_front();
            chk("latency", cyc - e.issue, e.lat);
            if (e.ld) chk("load_data", pipe_fetched_word, e.d);
         end
      end
   end

   // L2 transaction monitor; also commits write-backs to the memory model
   always @(negedge clk) begin
      lexp_t e;
      if (l2_req_valid && l2_req_fulfilled) begin
         if (lq.size() == 0) begin
            checks++; failures++;
            $display("FAIL l2_unexpected actual=%h required=none", l2_req_address);
         end else begin
            e = lq.pop_front();
            chk("l2_type", l2_req_type, e.st);
            chk("l2_addr", l2_req_address, e.a);
            if (e.st) chk("l2_wdata", l2_word_to_store, e.d);
         end
         if (l2_req_type == STORE) begin
            mem[l2_req_address] = l2_word_to_store;
            mem_gen++;
         end
      end
   end

   task automatic exp_fill(input logic [31:0] base);
      for (int i = 0; i < 4; i++) lq.push_back('{1'b0, base + 32'(4 * i), 32'h0});
   endtask

   // Issue one request (called at posedge+1), hold until fulfilled, release after the edge.
   task automatic req(input logic [31:0] a, input memory_operation_size_e sz,
                      input memory_operation_e ty, input logic [31:0] wd,
                      input logic [31:0] exp_d, input int exp_lat);
      bit done = 0;
      pq.push_back('{(ty == LOAD), exp_d, cyc, exp_lat});
      pipe_req_address   = a;
      pipe_req_size      = sz;
      pipe_req_type      = ty;
      pipe_word_to_store = wd;
      pipe_req_valid     = 1'b1;
      for (int k = 0; k < 40 && !done; k++) begin
         @(negedge clk);
         if (pipe_req_fulfilled) done = 1;
      end
      if (!done) begin
         checks++; failures++;
         $display("FAIL timeout actual=not_fulfilled required=fulfilled addr=%h", a);
         pq.delete();
      end
      @(posedge clk); #1;
      pipe_req_valid = 1'b0;
   endtask

   logic [31:0] bases [8] = '{32'h0000_0040, 32'h0000_A150, 32'h0010_0060, 32'h7FFF_FF70,
                              32'h0000_2280, 32'hFFFF_FF90, 32'h0000_55A0, 32'h1234_5BB0};
   int offs [4] = '{4, 9, 14, 3};
   memory_operation_size_e szs [4] = '{WORD, BYTE, HALF, BYTE};

   initial begin
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] a;
      reset_n = 1'b0;
      pipe_req_valid = 1'b0;
      pipe_req_address = '0;
      pipe_req_size = WORD;
      pipe_req_type = LOAD;
      pipe_word_to_store = '0;
      mem[32'h0000_1234] = 32'hDEAD_BEEF;
      mem_gen = 1;

      repeat (5) @(posedge clk);
      @(negedge clk);
      chk("rst_fulfilled", pipe_req_fulfilled, 0);
      chk("rst_l2_valid", l2_req_valid, 0);
      chk("rst_l2_type", l2_req_type, LOAD);
      chk("rst_l2_addr", l2_req_address, 0);
      chk("rst_fetched", pipe_fetched_word, 0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      // cold miss, then hits in the same line
      exp_fill(32'h1230);
      req(32'h1234, WORD, LOAD, 0, 32'hDEAD_BEEF, 5);
      req(32'h1237, BYTE, LOAD, 0, 32'h0000_00DE, 0);
      req(32'h1236, HALF, LOAD, 0, 32'h0000_DEAD, 0);
      req(32'h1234, BYTE, LOAD, 0, 32'h0000_00EF, 0);
      req(32'h1235, HALF, LOAD, 0, 32'h0000_BEEF, 0);
      req(32'h1237, WORD, LOAD, 0, 32'hDEAD_BEEF, 0);

      // 8 lines x 4 loads: first misses, remaining three hit
      for (int l = 0; l < 8; l++) begin
         exp_fill(bases[l]);
         for (int j = 0; j < 4; j++) begin
            a = bases[l] + 32'(offs[j]);
            req(a, szs[j], LOAD, 0, ext(rd(a & ~32'h3), a, szs[j]), (j == 0) ? 5 : 0);
         end
      end

      // dirty the line, then conflict miss forces write-back then fill
      req(32'h1234, BYTE, STORE, 32'hAAAA_AA55, 0, 0);
      lq.push_back('{1'b1, 32'h1230, dflt(32'h1230)});
      lq.push_back('{1'b1, 32'h1234, 32'hDEAD_BE55});
      lq.push_back('{1'b1, 32'h1238, dflt(32'h1238)});
      lq.push_back('{1'b1, 32'h123C, dflt(32'h123C)});
      exp_fill(32'h2230);
      req(32'h2234, WORD, LOAD, 0, dflt(32'h2234), 9);

      // reload the written-back line (clean victim now)
      exp_fill(32'h1230);
      req(32'h1234, BYTE, LOAD, 0, 32'h0000_0055, 5);
      req(32'h1237, BYTE, LOAD, 0, 32'h0000_00DE, 0);
      req(32'h1236, HALF, STORE, 32'hFFFF_ABCD, 0, 0);
      req(32'h1234, WORD, LOAD, 0, 32'hABCD_BE55, 0);

      // store miss allocates, then store lands
      exp_fill(32'h3340);
      req(32'h3348, WORD, STORE, 32'hCAFE_F00D, 0, 5);
      req(32'h3348, WORD, LOAD, 0, 32'hCAFE_F00D, 0);
      req(32'h334B, BYTE, LOAD, 0, 32'h0000_00CA, 0);

      // reset during fill word 2
      lq.push_back('{1'b0, 32'h5670, 32'h0});
      lq.push_back('{1'b0, 32'h5674, 32'h0});
      pipe_req_address = 32'h5674;
      pipe_req_size = WORD;
      pipe_req_type = LOAD;
      pipe_req_valid = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b0;
      pipe_req_valid = 1'b0;
      @(negedge clk);
      chk("midfill_rst_l2_valid", l2_req_valid, 0);
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk); #1;
      exp_fill(32'h5670);
      req(32'h5674, WORD, LOAD, 0, rd(32'h5674), 5);
      // reset also discarded the dirty line: memory still holds the written-back word
      exp_fill(32'h1230);
      req(32'h1234, WORD, LOAD, 0, 32'hDEAD_BE55, 5);

      repeat (2) @(negedge clk);
      chk("pipe_queue_empty", pq.size(), 0);
      chk("l2_queue_empty", lq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
